// File: rtl/horner_pkg.sv
// rtl/horner_pkg.sv - shared state encoding, default widths and coefficient addressing for the Horner sequencer
package horner_pkg;

   localparam int DEGREE_DEF      = 2;
   localparam int MAC_LATENCY_DEF = 3;
   localparam int SEG_BITS_DEF    = 7;
   localparam int X_W_DEF         = 40;
   localparam int ACC_W_DEF       = 54;
   localparam int COEF_W_DEF      = 30;
   localparam int ADDR_W_DEF      = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_LEAD,
      ST_LOAD,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } horner_state_e;

   // Segments are packed back to back, DEGREE+1 coefficients each, C0 at the lowest address.
   function automatic logic [31:0] coef_addr_f(input logic [31:0] seg,
                                               input logic [31:0] k,
                                               input int unsigned degree);
      return seg * (degree + 1) + k;
   endfunction

endpackage

// File: rtl/horner_eval_ctrl.sv
// rtl/horner_eval_ctrl.sv - sequences acc = acc*x - C_k through an external multiply-add stage
module horner_eval_ctrl
   import horner_pkg::*;
#(
   parameter int DEGREE      = DEGREE_DEF,
   parameter int MAC_LATENCY = MAC_LATENCY_DEF,
   parameter int SEG_BITS    = SEG_BITS_DEF,
   parameter int X_W         = X_W_DEF,
   parameter int ACC_W       = ACC_W_DEF,
   parameter int COEF_W      = COEF_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [X_W-1:0]      in_x,
   input  logic [SEG_BITS-1:0] in_seg,
   output logic                coef_rd,
   output logic [ADDR_W-1:0]   coef_addr,
   input  logic [COEF_W-1:0]   coef_data,
   output logic                mac_start,
   output logic [X_W-1:0]      mac_a,
   output logic [ACC_W-1:0]    mac_b,
   output logic [COEF_W-1:0]   mac_c,
   input  logic [ACC_W-1:0]    mac_result,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACC_W-1:0]    out_y
);

   localparam int K_W = (DEGREE < 1) ? 1 : $clog2(DEGREE + 1);
   localparam int T_W = $clog2(MAC_LATENCY + 1);
   localparam logic [K_W-1:0] K_LEAD = K_W'(DEGREE);
   localparam logic [K_W-1:0] K_NEXT = K_W'((DEGREE > 0) ? DEGREE - 1 : 0);

   horner_state_e       state_q;
   horner_state_e       state_d;
   logic [X_W-1:0]      x_q;
   logic [SEG_BITS-1:0] seg_q;
   logic [K_W-1:0]      k_q;
   logic [ACC_W-1:0]    acc_q;
   logic [T_W-1:0]      timer_q;
   logic                last_wait;

   assign last_wait = (timer_q == T_W'(1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:       if (in_valid) state_d = ST_FETCH_LEAD;
         ST_FETCH_LEAD: state_d = ST_LOAD;
         ST_LOAD:       state_d = (DEGREE == 0) ? ST_DONE : ST_FETCH;
         ST_FETCH:      state_d = ST_ISSUE;
         ST_ISSUE:      state_d = ST_WAIT;
         ST_WAIT:       if (last_wait) state_d = (k_q == '0) ? ST_DONE : ST_FETCH;
         ST_DONE:       if (out_ready) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   // Operands are registered at ISSUE and held through WAIT so the stage sees them stable.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_q       <= '0;
         seg_q     <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         timer_q   <= '0;
         mac_start <= 1'b0;
         mac_a     <= '0;
         mac_b     <= '0;
         mac_c     <= '0;
      end else begin
         mac_start <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  x_q   <= in_x;
                  seg_q <= in_seg;
                  k_q   <= K_LEAD;
               end
            end
            ST_LOAD: begin
               acc_q <= ACC_W'(coef_data);
               k_q   <= K_NEXT;
            end
            ST_ISSUE: begin
               mac_a     <= x_q;
               mac_b     <= acc_q;
               mac_c     <= coef_data;
               mac_start <= 1'b1;
               timer_q   <= T_W'(MAC_LATENCY);
            end
            ST_WAIT: begin
               timer_q <= timer_q - 1'b1;
               if (last_wait) begin
                  acc_q <= mac_result;
                  if (k_q != '0) k_q <= k_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      coef_rd   = (state_q == ST_FETCH_LEAD) || (state_q == ST_FETCH);
      coef_addr = '0;
      if (coef_rd) coef_addr = ADDR_W'(coef_addr_f(32'(seg_q), 32'(k_q), DEGREE));
      out_valid = (state_q == ST_DONE);
      out_y     = out_valid ? acc_q : '0;
   end

endmodule

// File: tb/tb_horner_eval_ctrl.sv
// tb/tb_horner_eval_ctrl.sv - scoreboard bench for horner_eval_ctrl with behavioral ROM and multiply-add stage
module tb_horner_eval_ctrl;

   localparam int LAT = 3;

   logic clock;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic        d_in_valid, d_in_ready, d_coef_rd, d_mac_start, d_out_valid, d_out_ready;
   logic [39:0] d_in_x, d_mac_a;
   logic [6:0]  d_in_seg;
   logic [9:0]  d_coef_addr;
   logic [29:0] d_coef_data, d_mac_c;
   logic [53:0] d_mac_b, d_mac_result, d_out_y;

   logic        z_in_valid, z_in_ready, z_coef_rd, z_mac_start, z_out_valid, z_out_ready;
   logic [39:0] z_in_x, z_mac_a;
   logic [6:0]  z_in_seg;
   logic [9:0]  z_coef_addr;
   logic [29:0] z_coef_data, z_mac_c;
   logic [53:0] z_mac_b, z_mac_result, z_out_y;

   horner_eval_ctrl #(.MAC_LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .in_x(d_in_x), .in_seg(d_in_seg),
      .coef_rd(d_coef_rd), .coef_addr(d_coef_addr), .coef_data(d_coef_data),
      .mac_start(d_mac_start), .mac_a(d_mac_a), .mac_b(d_mac_b), .mac_c(d_mac_c),
      .mac_result(d_mac_result),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .out_y(d_out_y)
   );

   horner_eval_ctrl #(.DEGREE(0), .MAC_LATENCY(LAT)) dut_z (
      .clock(clock), .reset(reset),
      .in_valid(z_in_valid), .in_ready(z_in_ready), .in_x(z_in_x), .in_seg(z_in_seg),
      .coef_rd(z_coef_rd), .coef_addr(z_coef_addr), .coef_data(z_coef_data),
      .mac_start(z_mac_start), .mac_a(z_mac_a), .mac_b(z_mac_b), .mac_c(z_mac_c),
      .mac_result(z_mac_result),
      .out_valid(z_out_valid), .out_ready(z_out_ready), .out_y(z_out_y)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioral ROMs, one-cycle read latency
   logic [29:0] d_rom [0:1023];
   logic [29:0] z_rom [0:1023];
   always @(posedge clock) begin
      if (d_coef_rd) d_coef_data <= d_rom[d_coef_addr];
      if (z_coef_rd) z_coef_data <= z_rom[z_coef_addr];
   end

   // Behavioral multiply-add: operands visible in the first WAIT cycle, result by the last
   logic signed [95:0] pa, pb, pc, pr;
   logic [53:0] mac_pipe [0:LAT-2];
   always_comb begin
      pa = {{56{d_mac_a[39]}}, d_mac_a};
      pb = {{42{d_mac_b[53]}}, d_mac_b};
      pc = {66'd0, d_mac_c};
      pr = pa * pb - pc;
   end
   always @(posedge clock) begin
      mac_pipe[0] <= pr[53:0];
      for (int i = 1; i < LAT - 1; i++) mac_pipe[i] <= mac_pipe[i-1];
   end
   assign d_mac_result = mac_pipe[LAT-2];
   assign z_mac_result = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   logic [53:0] d_q[$];
   logic [53:0] z_q[$];
   logic [9:0]  d_addr_log[$];
   int d_hs = 0, z_hs = 0, d_hs_cyc = 0;
   int d_ms = 0, z_ms = 0;
   int d_rise_cyc = 0, z_rise_cyc = 0;
   logic d_prev_ov = 1'b0, z_prev_ov = 1'b0;

   // Monitors: sample mid-cycle, pop the scoreboard on each output handshake
   always @(negedge clock) begin
      if (!reset) begin
         if (d_out_valid && d_out_ready) begin
            if (d_q.size() == 0) check("d_unexpected_output", 64'(d_out_y), 64'hDEAD);
            else check("d_out_y", 64'(d_out_y), 64'(d_q.pop_front()));
            d_hs++;
            d_hs_cyc = cyc;
         end
         if (z_out_valid && z_out_ready) begin
            if (z_q.size() == 0) check("z_unexpected_output", 64'(z_out_y), 64'hDEAD);
            else check("z_out_y", 64'(z_out_y), 64'(z_q.pop_front()));
            z_hs++;
         end
         if (d_out_valid && !d_prev_ov) d_rise_cyc = cyc;
         if (z_out_valid && !z_prev_ov) z_rise_cyc = cyc;
         if (d_mac_start) d_ms++;
         if (z_mac_start) z_ms++;
         if (d_coef_rd) d_addr_log.push_back(d_coef_addr);
      end
      d_prev_ov = d_out_valid;
      z_prev_ov = z_out_valid;
   end

   // Tasks start and end in the drive phase (1 time unit after a posedge).
   task automatic send_d(input logic [6:0] seg, input logic [39:0] x, output int t);
      t = -1;
      d_in_valid = 1'b1; d_in_seg = seg; d_in_x = x;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (d_in_ready) begin t = cyc; break; end
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
      d_in_valid = 1'b0; d_in_x = 40'hA5_A5A5_A5A5; d_in_seg = 7'h55;
      if (t < 0) check("d_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_z(input logic [6:0] seg, input logic [39:0] x, output int t);
      t = -1;
      z_in_valid = 1'b1; z_in_seg = seg; z_in_x = x;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (z_in_ready) begin t = cyc; break; end
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
      z_in_valid = 1'b0; z_in_seg = 7'h55;
      if (t < 0) check("z_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_hs_d(input int n);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clock); #1;
         if (d_hs >= n) done = 1'b1;
      end
      if (!done) check("d_handshake_timeout", 64'(d_hs), 64'(n));
   endtask

   task automatic wait_hs_z(input int n);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clock); #1;
         if (z_hs >= n) done = 1'b1;
      end
      if (!done) check("z_handshake_timeout", 64'(z_hs), 64'(n));
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready",  64'(d_in_ready),  64'd1);
      check("rst_out_valid", 64'(d_out_valid), 64'd0);
      check("rst_coef_rd",   64'(d_coef_rd),   64'd0);
      check("rst_mac_start", 64'(d_mac_start), 64'd0);
      check("rst_coef_addr", 64'(d_coef_addr), 64'd0);
      check("rst_mac_a",     64'(d_mac_a),     64'd0);
      check("rst_mac_b",     64'(d_mac_b),     64'd0);
      check("rst_mac_c",     64'(d_mac_c),     64'd0);
      check("rst_out_y",     64'(d_out_y),     64'd0);
   endtask

   initial begin
      int t, ms0, n;
      reset = 1'b1;
      d_in_valid = 1'b0; d_in_x = '0; d_in_seg = '0; d_out_ready = 1'b1;
      z_in_valid = 1'b0; z_in_x = '0; z_in_seg = '0; z_out_ready = 1'b1;
      for (int i = 0; i < 1024; i++) begin d_rom[i] = '0; z_rom[i] = '0; end
      d_rom[0] = 30'd5;  d_rom[1] = 30'd2;  d_rom[2] = 30'd1;         // seg 0
      d_rom[3] = 30'd3;  d_rom[4] = 30'd0;  d_rom[5] = 30'd1;         // seg 1
      d_rom[15] = 30'd7; d_rom[16] = 30'd0; d_rom[17] = 30'd0;        // seg 5
      d_rom[30] = 30'd0; d_rom[31] = 30'd0; d_rom[32] = 30'h2000_0000; // seg 10
      z_rom[3] = 30'd9;                                              // DEGREE=0, seg 3
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check_reset_outputs();
      @(posedge clock); #1;

      // seg 0, x=3: 1 -> 1 -> -2, 13-cycle latency, two issues
      n = 1; ms0 = d_ms; d_addr_log.delete();
      d_q.push_back(-54'sd2);
      send_d(7'd0, 40'd3, t);
      wait_hs_d(n);
      check("lat_seg0", 64'(d_rise_cyc - t), 64'd13);
      check("mac_start_seg0", 64'(d_ms - ms0), 64'd2);
      check("addr_cnt_seg0", 64'(d_addr_log.size()), 64'd3);

      // seg 5, x=-4: addresses 17,16,15, result -7
      n++; d_addr_log.delete();
      d_q.push_back(-54'sd7);
      send_d(7'd5, -40'sd4, t);
      wait_hs_d(n);
      check("addr_cnt_seg5", 64'(d_addr_log.size()), 64'd3);
      if (d_addr_log.size() == 3) begin
         check("addr0_seg5", 64'(d_addr_log[0]), 64'd17);
         check("addr1_seg5", 64'(d_addr_log[1]), 64'd16);
         check("addr2_seg5", 64'(d_addr_log[2]), 64'd15);
      end

      // Backpressure: seg 1, x=5 -> 1,5,22 held while out_ready is low
      n++;
      d_out_ready = 1'b0;
      d_q.push_back(54'd22);
      send_d(7'd1, 40'd5, t);
      for (int i = 0; i < 100 && !d_out_valid; i++) @(negedge clock);
      check("stall_valid_seen", 64'(d_out_valid), 64'd1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         if (i == 3) begin d_in_valid = 1'b1; d_in_seg = 7'd0; d_in_x = 40'd3; end
         if (i == 8) d_in_valid = 1'b0;
         @(negedge clock);
         check("stall_out_y", 64'(d_out_y), 64'd22);
         check("stall_in_ready", 64'(d_in_ready), 64'd0);
         check("stall_out_valid", 64'(d_out_valid), 64'd1);
      end
      @(posedge clock); #1;
      d_out_ready = 1'b1;
      wait_hs_d(n);
      n++;
      d_q.push_back(-54'sd2);
      send_d(7'd0, 40'd3, t);
      check("accept_after_hs", 64'(t), 64'(d_hs_cyc + 1));
      wait_hs_d(n);

      // Reset at accept+6 aborts; the following transaction must be clean
      send_d(7'd0, 40'd3, t);
      for (int i = 0; i < 50 && cyc < t + 6; i++) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check_reset_outputs();
      @(posedge clock); #1;
      n++;
      d_q.push_back(54'd1);
      send_d(7'd1, 40'd2, t);
      wait_hs_d(n);
      check("hs_count_after_reset", 64'(d_hs), 64'(n));

      // Wrap: 2^29 -> -2^29 -> 2^29 modulo 2^54
      n++;
      d_q.push_back(54'h000_0000_2000_0000);
      send_d(7'd10, 40'h7F_FFFF_FFFF, t);
      wait_hs_d(n);

      // DEGREE=0 build: C0 straight to output at accept+3
      ms0 = z_ms;
      z_q.push_back(54'd9);
      send_z(7'd3, 40'd7, t);
      wait_hs_z(1);
      check("lat_deg0", 64'(z_rise_cyc - t), 64'd3);
      check("mac_start_deg0", 64'(z_ms - ms0), 64'd0);

      check("d_queue_empty", 64'(d_q.size()), 64'd0);
      check("z_queue_empty", 64'(z_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout actual=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/horner_eval_ctrl.md
# horner_eval_ctrl

Sequencer that drives the Horner multiply-add stage of the AWGN datapath. It accepts one argument x and one segment index per transaction and fetches that segment's polynomial coefficients from an external coefficient ROM. It then iterates acc = acc·x − C_k through the multiply-add stage, DEGREE passes in all, and returns the final accumulator on a valid/ready output. It sits between the uniform-to-segment front end and the log/sqrt approximation output.

## Interface
- DEGREE, 2: polynomial degree; ROM holds DEGREE+1 coefficients per segment.
- MAC_LATENCY, 3: cycles from operand presentation to a valid mac_result.
- SEG_BITS, 7: segment index width.
- X_W, 40: argument width (signed).
- ACC_W, 54: accumulator and mac_result width (signed).
- COEF_W, 30: coefficient width (unsigned magnitude).
- ADDR_W, 10: coefficient ROM address width.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  argument/segment valid.
- in_ready  out  1  high only in IDLE.
- in_x  in  X_W  argument.
- in_seg  in  SEG_BITS  segment index.
- coef_rd  out  1  ROM read strobe.
- coef_addr  out  ADDR_W  ROM address.
- coef_data  in  COEF_W  ROM data, valid the cycle after coef_rd.
- mac_start  out  1  one-cycle pulse when operands are first presented.
- mac_a  out  X_W  multiplier operand (x).
- mac_b  out  ACC_W  multiplicand (acc).
- mac_c  out  COEF_W  subtrahend (C_k).
- mac_result  in  ACC_W  a·b − c, valid MAC_LATENCY cycles after operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_y  out  ACC_W  polynomial value.

## Operation
- States: IDLE, FETCH_LEAD, LOAD, FETCH, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. When in_valid is high, latch in_x and in_seg, set k=DEGREE, then go to FETCH_LEAD.
- FETCH_LEAD: coef_rd=1, coef_addr=seg·(DEGREE+1)+DEGREE. Go to LOAD.
- LOAD: acc ← zero-extended coef_data, k ← DEGREE−1. Go to FETCH.
- FETCH: coef_rd=1, coef_addr=seg·(DEGREE+1)+k. Go to ISSUE.
- ISSUE: register mac_c ← coef_data, mac_a ← x, mac_b ← acc, and pulse mac_start. Go to WAIT with the timer set to MAC_LATENCY.
- WAIT: operands are held stable. On the last WAIT cycle, acc ← mac_result.
  - If k==0, go to DONE.
  - Otherwise k ← k−1 and go to FETCH.
- DONE: out_valid=1, out_y=acc. Hold until out_ready, then go to IDLE.
- The subtract convention is fixed. Coefficients are stored as magnitudes and the stage subtracts.
- The block performs no saturation. acc wraps modulo 2^ACC_W.
- coef_addr is computed at full width and truncated to ADDR_W. Callers guarantee (2^SEG_BITS)(DEGREE+1) ≤ 2^ADDR_W.
- in_valid is ignored outside IDLE. in_x and in_seg may change freely after acceptance.

## Timing
- Reset values: state=IDLE, in_ready=1 from the first cycle after reset deasserts, out_valid=0, coef_rd=0, mac_start=0, and coef_addr, mac_a, mac_b, mac_c, out_y all 0.
- Reset mid-transaction aborts with no output. The in-flight mac_result is ignored.
- Accept occurs on cycle t.
  - FETCH_LEAD is t+1 and LOAD is t+2.
  - Each step is 2+MAC_LATENCY cycles.
  - out_valid first rises in cycle t+3+DEGREE·(MAC_LATENCY+2). With default parameters this is t+13.
- out_valid is held with out_y stable until out_ready. The handshake completes on the edge where both are high.
- After out handshake cycle u, in_ready is high in u+1. Throughput is one result per latency+2 cycles minimum.
- DEGREE=0: LOAD goes directly to DONE. Latency is 3 cycles and no mac_start pulse is issued.

## Structure
- horner_pkg holds:
  - the state enum;
  - default parameter constants DEGREE, MAC_LATENCY, X_W, ACC_W, COEF_W;
  - the coefficient address function seg·(DEGREE+1)+k.
- The multiply-add stage also imports these widths.
- The RTL is a single module with no sub-module.
- The bench supplies a behavioral MAC model with programmable MAC_LATENCY and a behavioral ROM with 1-cycle latency.

## Test plan
- Seg 0 holds C2=1, C1=2, C0=5; send x=3 with out_ready=1.
  - Required: out_y=−2 (1→1→−2).
  - out_valid rises exactly 13 cycles after accept.
  - Exactly 2 mac_start pulses.
- Seg 5 holds C2=0, C1=0, C0=7; send x=−4.
  - Required: coef_addr sequence 17, 16, 15.
  - out_y=−7.
- out_ready held low for 20 cycles after out_valid.
  - Required: out_y stable, in_ready=0, and a second in_valid is ignored.
  - After the release, the next transaction starts the cycle after the handshake.
- Assert reset for 1 cycle at accept+6, then drive a new transaction.
  - Required: outputs return to their reset values, and the new transaction result is correct.
  - No stale acc from the aborted transaction.
- Wrap case: C2=2^29, C1=0, C0=0, x=2^39−1.
  - Required: out_y equals the two's-complement product truncated to 54 bits, with no saturation.
- DEGREE=0 build with C0=9.
  - Required: out_y=9 at accept+3.
  - No mac_start pulse.
